// File: rtl/fft_pkg.sv
// Shared types and constants for the streaming FFT datapath.
package fft_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int CPLX_W    = DEF_WIDTH + 1;

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_BFLY = 1'b1
    } phase_e;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/sdf_delay_line.sv
// NUM-deep shift register of complex entries; head is the oldest entry.
module sdf_delay_line #(
    parameter int NUM   = 16,
    parameter int WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [2*WIDTH-1:0]   din,
    output logic [2*WIDTH-1:0]   head
);

    logic [2*WIDTH-1:0] mem [NUM];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < NUM - 1; i++) begin
                mem[i] <= mem[i+1];
            end
            mem[NUM-1] <= din;
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/sdf_bfly_stage.sv
// Radix-2 SDF butterfly stage: pairs x[n] with x[n+NUM], emits sums during
// the butterfly phase and the stored differences during the next fill phase.
module sdf_bfly_stage
    import fft_pkg::*;
#(
    parameter int NUM   = 16,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [1:0]              bfly_enable,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    output logic signed [WIDTH:0]   dout_re,
    output logic signed [WIDTH:0]   dout_im,
    output logic                    valid_o
);

    localparam int CW = WIDTH + 1;

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } cplx_w_t;

    phase_e   ph;
    cplx_w_t  a;
    cplx_w_t  b;
    cplx_w_t  sum;
    cplx_w_t  diff;
    cplx_w_t  push;
    cplx_w_t  nxt_dout;
    logic [2*CW-1:0] head;
    logic     diff_ready;
    logic     unused_reserved;

    // bfly_enable[1] is reserved by the upstream counter
    assign unused_reserved = bfly_enable[1];
    assign ph = phase_e'(bfly_enable[0]);

    assign a    = cplx_w_t'(head);
    assign b.re = {din_re[WIDTH-1], din_re};
    assign b.im = {din_im[WIDTH-1], din_im};

    // One guard bit is enough: both operands are WIDTH-bit values widened by one.
    assign sum.re  = a.re + b.re;
    assign sum.im  = a.im + b.im;
    assign diff.re = a.re - b.re;
    assign diff.im = a.im - b.im;

    always_comb begin
        push     = b;
        nxt_dout = a;
        if (ph == PH_BFLY) begin
            push     = diff;
            nxt_dout = sum;
        end
    end

    sdf_delay_line #(
        .NUM   (NUM),
        .WIDTH (CW)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .shift_en (valid_i),
        .din      (push),
        .head     (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_re    <= '0;
            dout_im    <= '0;
            valid_o    <= 1'b0;
            diff_ready <= 1'b0;
        end else if (valid_i) begin
            dout_re <= nxt_dout.re;
            dout_im <= nxt_dout.im;
            if (ph == PH_BFLY) begin
                valid_o    <= 1'b1;
                diff_ready <= 1'b1;
            end else begin
                // nothing to drain until at least one butterfly block has run
                valid_o <= diff_ready;
            end
        end else begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdf_bfly_stage.sv
// Scoreboard bench for sdf_bfly_stage (NUM=4, WIDTH=8) against a queue-based model.
module tb_sdf_bfly_stage;

    localparam int NUM   = 4;
    localparam int WIDTH = 8;

    typedef struct {
        int re;
        int im;
    } cval_t;

    typedef struct {
        int stamp;
        int re;
        int im;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    valid_i = 1'b0;
    logic [1:0]              bfly_enable = 2'b00;
    logic signed [WIDTH-1:0] din_re = '0;
    logic signed [WIDTH-1:0] din_im = '0;
    logic signed [WIDTH:0]   dout_re;
    logic signed [WIDTH:0]   dout_im;
    logic                    valid_o;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    logic  vi_s = 1'b0;

    cval_t dl[$];
    exp_t  sb[$];
    bit    ready = 0;
    int    ph_cnt = 0;
    int    blk_re[NUM];
    int    blk_im[NUM];

    sdf_bfly_stage #(.NUM(NUM), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .bfly_enable (bfly_enable),
        .din_re      (din_re),
        .din_im      (din_im),
        .dout_re     (dout_re),
        .dout_im     (dout_im),
        .valid_o     (valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  = cyc + 1;
        vi_s <= valid_i;
    end

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        dl.delete();
        for (int i = 0; i < NUM; i++) dl.push_back('{0, 0});
        sb.delete();
        ready  = 0;
        ph_cnt = 0;
    endtask

    // Pairs each incoming sample with the one NUM samples earlier.
    task automatic model_step(bit ph, int re, int im);
        cval_t a;
        a = dl.pop_front();
        if (ph) begin
            sb.push_back('{cyc + 1, a.re + re, a.im + im});
            dl.push_back('{a.re - re, a.im - im});
            ready = 1;
        end else begin
            if (ready) sb.push_back('{cyc + 1, a.re, a.im});
            dl.push_back('{re, im});
        end
    endtask

    task automatic send(int re, int im);
        bit ph;
        logic r1;
        ph = (ph_cnt >= NUM);
        r1 = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        valid_i     = 1'b1;
        din_re      = re[WIDTH-1:0];
        din_im      = im[WIDTH-1:0];
        bfly_enable = {r1, ph};
        model_step(ph, re, im);
        ph_cnt = (ph_cnt + 1) % (2 * NUM);
    endtask

    // Idle cycles with scrambled phase/data to prove they are ignored.
    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_i     = 1'b0;
            bfly_enable = 2'($urandom_range(0, 3));
            din_re      = 8'($urandom_range(0, 255));
            din_im      = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic run_block(int gap);
        for (int i = 0; i < NUM; i++) begin
            send(blk_re[i], blk_im[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic set_blk(int r0, int r1, int r2, int r3, int i0, int i1, int i2, int i3);
        blk_re = '{r0, r1, r2, r3};
        blk_im = '{i0, i1, i2, i3};
    endtask

    task automatic rand_blk();
        for (int i = 0; i < NUM; i++) begin
            blk_re[i] = int'($urandom_range(0, 255)) - 128;
            blk_im[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    int last_re = 0;
    int last_im = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last_re = 0;
            last_im = 0;
        end else begin
            if (valid_o) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got re=%0d im=%0d, expected no output (cycle %0d)",
                             int'(dout_re), int'(dout_im), cyc);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.stamp);
                    check("dout_re", int'(dout_re), e.re);
                    check("dout_im", int'(dout_im), e.im);
                end
            end else begin
                tests++;
                if (sb.size() != 0 && sb[0].stamp <= cyc) begin
                    fails++;
                    $display("FAIL missed_out: got valid_o=0, expected re=%0d im=%0d (cycle %0d)",
                             sb[0].re, sb[0].im, cyc);
                    void'(sb.pop_front());
                end
                if (!vi_s) begin
                    check("hold_re", int'(dout_re), last_re);
                    check("hold_im", int'(dout_im), last_im);
                end
            end
            last_re = int'(dout_re);
            last_im = int'(dout_im);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        check("reset_valid_o", int'(valid_o), 0);
        check("reset_dout_re", int'(dout_re), 0);
        check("reset_dout_im", int'(dout_im), 0);
        @(negedge clk);
        rst = 1'b1;

        // fill, butterfly, drain
        set_blk(1, 2, 3, 4, 0, 0, 0, 0);     run_block(0);
        set_blk(10, 20, 30, 40, 0, 0, 0, 0); run_block(0);
        set_blk(0, 0, 0, 0, 0, 0, 0, 0);     run_block(0);
        set_blk(10, 20, 30, 40, 0, 0, 0, 0); run_block(0);

        // same pattern with 3-cycle gaps
        set_blk(1, 2, 3, 4, 0, 0, 0, 0);     run_block(3);
        set_blk(10, 20, 30, 40, 0, 0, 0, 0); run_block(3);

        // width growth extremes
        set_blk(127, -128, 127, -128, 0, 0, 0, 0); run_block(0);
        set_blk(127, 127, -128, -128, 0, 0, 0, 0); run_block(1);

        // imaginary independence
        set_blk(0, 0, 0, 0, 5, -5, 0, 1); run_block(0);
        set_blk(0, 0, 0, 0, 2, 2, 2, 2);  run_block(0);

        for (int f = 0; f < 12; f++) begin
            rand_blk();
            run_block(int'($urandom_range(0, 2)));
        end
        set_blk(0, 0, 0, 0, 0, 0, 0, 0); run_block(0);
        idle(3);

        // async reset in the middle of a butterfly block
        rand_blk(); run_block(0);
        rand_blk();
        send(blk_re[0], blk_im[0]);
        send(blk_re[1], blk_im[1]);
        @(posedge clk);
        #1 valid_i = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        #1;
        check("async_valid_o", int'(valid_o), 0);
        check("async_dout_re", int'(dout_re), 0);
        check("async_dout_im", int'(dout_im), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        rand_blk(); run_block(0);
        rand_blk(); run_block(1);
        set_blk(0, 0, 0, 0, 0, 0, 0, 0); run_block(0);
        idle(6);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
